// File: rtl/cache_line_xfer.sv
// cache_line_xfer: memory-side burst engine for 16-word line write-back
// (store) and line fill (load). One word moves per mem_req/mem_ack handshake.
// The control FSM consumes cnt, complete and fsm_en.

module cache_line_xfer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store,
    input  logic              load,
    input  logic [ADDR_W-7:0] line_addr,
    input  logic [DATA_W-1:0] cache_rdata,
    output logic [3:0]        cnt,
    output logic              complete,
    output logic              fsm_en,
    output logic              cache_we,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_BEAT = 2'd1,
        LD_BEAT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        complete_q, complete_d;

    // Next-state logic: burst sequencing, word counter and write-back-done flag
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        complete_d = complete_q;
        case (state_q)
            IDLE: begin
                // A finished write-back blocks a new store until a fill clears it
                if (store && !complete_q) begin
                    state_d = ST_BEAT;
                end else if (load) begin
                    state_d    = LD_BEAT;
                    complete_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ST_BEAT: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d    = IDLE;
                        complete_d = 1'b1;
                    end else begin
                        state_d = ST_BEAT;
                    end
                end else begin
                    state_d = ST_BEAT;
                end
            end
            LD_BEAT: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        state_d = LD_BEAT;
                    end
                end else begin
                    state_d = LD_BEAT;
                end
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = 4'd0;
                complete_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            complete_q <= complete_d;
        end
    end

    // Handshake outputs: request held until ack, FSM advances only on acked beats
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        fsm_en   = 1'b1;
        cache_we = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = 1'b0;
                fsm_en  = 1'b1;
            end
            ST_BEAT: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                fsm_en  = mem_ack;
            end
            LD_BEAT: begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                fsm_en   = mem_ack;
                cache_we = mem_ack;
            end
            default: begin
                mem_req  = 1'b0;
                mem_we   = 1'b0;
                fsm_en   = 1'b1;
                cache_we = 1'b0;
            end
        endcase
    end

    // Address is counter-derived, so it stays stable across a memory stall
    assign mem_addr    = {line_addr, cnt_q, 2'b00};
    assign mem_wdata   = cache_rdata;
    assign cache_wdata = mem_rdata;
    assign cnt         = cnt_q;
    assign complete    = complete_q;

endmodule

// File: tb/tb_cache_line_xfer.sv
// Self-checking bench for cache_line_xfer: randomized data/ack gaps checked
// against beat-level expectations (address = line base + 4*word index).

module tb_cache_line_xfer;

    logic        clk = 1'b0;
    logic        rst;
    logic        store, load, store_drv, load_drv, use_ctrl, miss_req;
    logic [25:0] line_addr;
    logic [31:0] cache_rdata, cache_wdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  cnt;
    logic        complete, fsm_en, cache_we, mem_req, mem_we, mem_ack;

    logic [31:0] src_arr [16];
    int          tests = 0;
    int          fails = 0;
    int          we_cnt = 0;

    typedef enum logic [1:0] {C_RD_WR, C_STORE, C_WAIT, C_LOAD} ctrl_t;
    ctrl_t ctrl_q, ctrl_d;

    always #5 clk = ~clk;

    // Data array read port model
    assign cache_rdata = src_arr[cnt];
    assign store = use_ctrl ? (ctrl_q == C_STORE) : store_drv;
    assign load  = use_ctrl ? (ctrl_q == C_LOAD)  : load_drv;

    cache_line_xfer #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .store(store), .load(load), .line_addr(line_addr),
        .cache_rdata(cache_rdata), .cnt(cnt), .complete(complete), .fsm_en(fsm_en),
        .cache_we(cache_we), .cache_wdata(cache_wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Cache control FSM next state (environment model)
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            C_RD_WR: if (miss_req) ctrl_d = C_STORE;
            C_STORE: if (cnt == 4'd15) ctrl_d = C_WAIT;
            C_WAIT:  if (complete) ctrl_d = C_LOAD;
            C_LOAD:  if (cnt == 4'd15) ctrl_d = C_RD_WR;
            default: ctrl_d = C_RD_WR;
        endcase
    end

    // Control FSM state register, advanced by the engine's fsm_en
    always @(posedge clk) begin
        if (rst) ctrl_q <= C_RD_WR;
        else if (fsm_en) ctrl_q <= ctrl_d;
    end

    // Count data-array write strobes
    always @(posedge clk) begin
        if (cache_we) we_cnt <= we_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1; store_drv = 1'b0; load_drv = 1'b0; use_ctrl = 1'b0; miss_req = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'd0; line_addr = 26'd0;
        for (int k = 0; k < 16; k++) src_arr[k] = 32'd0;
        tick; tick; #1;
        tests++;
        if ({cnt, complete, mem_req, fsm_en, cache_we} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got cnt=%0d cpl=%b req=%b en=%b we=%b, exp 0 0 0 1 0",
                     cnt, complete, mem_req, fsm_en, cache_we);
        end
        rst = 1'b0; line_addr = 26'h55; load_drv = 1'b1; mem_ack = 1'b1;
        tick;
        for (int i = 0; i < 7; i++) tick;
        #1;
        tests++;
        if ({mem_req, cnt} !== {1'b1, 4'd7}) begin
            fails++;
            $display("FAIL reset_pre_cnt: got req=%b cnt=%0d, exp 1 7", mem_req, cnt);
        end
        rst = 1'b1;
        tick; tick;
        rst = 1'b0; load_drv = 1'b0; mem_ack = 1'b0; #1;
        tests++;
        if ({cnt, complete, mem_req, fsm_en} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_midburst: got cnt=%0d cpl=%b req=%b en=%b, exp 0 0 0 1",
                     cnt, complete, mem_req, fsm_en);
        end
        tick; #1;
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_req: got req=%b exp 0", mem_req);
        end
    endtask

    task automatic test_fill_zero_wait;
        logic [31:0] base;
        line_addr = 26'h123;
        base = 32'(line_addr) * 32'd64;
        load_drv = 1'b1; mem_ack = 1'b1;
        tick;
        load_drv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_rdata = 32'hA0 + 32'(i);
            #1;
            tests++;
            if ({mem_req, mem_we, cache_we, fsm_en, cnt} !== {1'b1, 1'b0, 1'b1, 1'b1, 4'(i)}) begin
                fails++;
                $display("FAIL fill_ctrl[%0d]: got req=%b we=%b cwe=%b en=%b cnt=%0d, exp 1 0 1 1 %0d",
                         i, mem_req, mem_we, cache_we, fsm_en, cnt, i);
            end
            tests++;
            if ({mem_addr, cache_wdata} !== {base + 32'(4 * i), 32'hA0 + 32'(i)}) begin
                fails++;
                $display("FAIL fill_addr_data[%0d]: got %h/%h exp %h/%h", i, mem_addr,
                         cache_wdata, base + 32'(4 * i), 32'hA0 + 32'(i));
            end
            tick;
        end
        mem_ack = 1'b0; #1;
        tests++;
        if ({cnt, mem_req, complete} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL fill_end: got cnt=%0d req=%b cpl=%b exp 0 0 0", cnt, mem_req, complete);
        end
    endtask

    task automatic test_writeback_latency;
        logic [31:0] base;
        line_addr = 26'($urandom);
        base = 32'(line_addr) * 32'd64;
        for (int k = 0; k < 16; k++) src_arr[k] = $urandom;
        store_drv = 1'b1; mem_ack = 1'b0;
        tick;
        store_drv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 3; c++) begin
                mem_ack = (c == 2);
                #1;
                tests++;
                if ({mem_req, mem_we, cache_we, fsm_en, complete} !==
                    {1'b1, 1'b1, 1'b0, mem_ack, 1'b0}) begin
                    fails++;
                    $display("FAIL wb_ctrl[%0d.%0d]: got req=%b we=%b cwe=%b en=%b cpl=%b ack=%b",
                             i, c, mem_req, mem_we, cache_we, fsm_en, complete, mem_ack);
                end
                tests++;
                if ({mem_addr, mem_wdata} !== {base + 32'(4 * i), src_arr[i]}) begin
                    fails++;
                    $display("FAIL wb_addr_data[%0d.%0d]: got %h/%h exp %h/%h", i, c, mem_addr,
                             mem_wdata, base + 32'(4 * i), src_arr[i]);
                end
                tick;
            end
        end
        mem_ack = 1'b0; #1;
        tests++;
        if ({complete, cnt, mem_req} !== {1'b1, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL wb_end: got cpl=%b cnt=%0d req=%b exp 1 0 0", complete, cnt, mem_req);
        end
    endtask

    task automatic test_store_blocked;
        store_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if ({mem_req, complete} !== {1'b0, 1'b1}) begin
                fails++;
                $display("FAIL store_blocked[%0d]: got req=%b cpl=%b exp 0 1", i, mem_req, complete);
            end
            tick;
        end
        load_drv = 1'b1;
        tick; #1;
        tests++;
        if ({complete, mem_req, mem_we} !== {1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL load_clears: got cpl=%b req=%b we=%b exp 0 1 0", complete, mem_req, mem_we);
        end
        store_drv = 1'b0; load_drv = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem_rdata = $urandom;
            tick;
        end
        mem_ack = 1'b0; #1;
        tests++;
        if ({mem_req, cnt} !== {1'b0, 4'd0}) begin
            fails++;
            $display("FAIL blocked_fill_end: got req=%b cnt=%0d exp 0 0", mem_req, cnt);
        end
    endtask

    task automatic test_priority;
        store_drv = 1'b1; load_drv = 1'b1; mem_ack = 1'b0;
        tick; #1;
        tests++;
        if ({mem_req, mem_we} !== {1'b1, 1'b1}) begin
            fails++;
            $display("FAIL priority: got req=%b we=%b exp 1 1", mem_req, mem_we);
        end
        store_drv = 1'b0; load_drv = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 16; i++) tick;
        mem_ack = 1'b0; #1;
        tests++;
        if ({complete, mem_req} !== {1'b1, 1'b0}) begin
            fails++;
            $display("FAIL priority_end: got cpl=%b req=%b exp 1 0", complete, mem_req);
        end
    endtask

    task automatic test_fill_random;
        logic [31:0] base, exp_d;
        logic [15:0] seen;
        int          we0, gap;
        seen = 16'd0;
        line_addr = 26'($urandom);
        base = 32'(line_addr) * 32'd64;
        we0 = we_cnt;
        load_drv = 1'b1; mem_ack = 1'b0;
        tick;
        load_drv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'b0; #1;
                tests++;
                if ({mem_req, cache_we, fsm_en, cnt, mem_addr} !==
                    {1'b1, 1'b0, 1'b0, 4'(i), base + 32'(4 * i)}) begin
                    fails++;
                    $display("FAIL rnd_stall[%0d]: got req=%b cwe=%b en=%b cnt=%0d addr=%h",
                             i, mem_req, cache_we, fsm_en, cnt, mem_addr);
                end
                tick;
            end
            mem_ack = 1'b1; mem_rdata = $urandom; exp_d = mem_rdata; #1;
            tests++;
            if ({cache_we, fsm_en, cnt, cache_wdata, mem_addr} !==
                {1'b1, 1'b1, 4'(i), exp_d, base + 32'(4 * i)} || seen[cnt] !== 1'b0) begin
                fails++;
                $display("FAIL rnd_beat[%0d]: got cwe=%b en=%b cnt=%0d d=%h addr=%h dup=%b",
                         i, cache_we, fsm_en, cnt, cache_wdata, mem_addr, seen[cnt]);
            end
            seen[cnt] = 1'b1;
            tick;
        end
        mem_ack = 1'b0; #1;
        tests++;
        if ({we_cnt - we0, seen, cnt, mem_req} !== {32'sd16, 16'hFFFF, 4'd0, 1'b0}) begin
            fails++;
            $display("FAIL rnd_end: got writes=%0d seen=%h cnt=%0d req=%b exp 16 ffff 0 0",
                     we_cnt - we0, seen, cnt, mem_req);
        end
    endtask

    task automatic test_full_miss;
        int n_st, n_wt, n_ld, st_beats, ld_beats, ld_idx, cyc;
        logic cpl0, cpl1;
        n_st = 0; n_wt = 0; n_ld = 0; st_beats = 0; ld_beats = 0; ld_idx = 0;
        cpl0 = 1'b0; cpl1 = 1'b1;
        line_addr = 26'($urandom);
        use_ctrl = 1'b1; mem_ack = 1'b1; miss_req = 1'b1;
        tick;
        miss_req = 1'b0;
        cyc = 0;
        while (ctrl_q != C_RD_WR && cyc < 100) begin
            mem_rdata = $urandom; #1;
            case (ctrl_q)
                C_STORE: n_st++;
                C_WAIT:  n_wt++;
                C_LOAD: begin
                    if (ld_idx == 0) cpl0 = complete;
                    if (ld_idx == 1) cpl1 = complete;
                    ld_idx++;
                    n_ld++;
                end
                default: ;
            endcase
            if (mem_req && mem_ack && mem_we) st_beats++;
            if (mem_req && mem_ack && !mem_we) ld_beats++;
            cyc++;
            tick;
        end
        mem_ack = 1'b0;
        tests++;
        if (cyc >= 100) begin
            fails++;
            $display("FAIL miss_timeout: ctrl did not return to RD_WR within 100 cycles");
        end
        tests++;
        if ({n_st, n_wt, n_ld, st_beats, ld_beats} !== {32'sd17, 32'sd1, 32'sd17, 32'sd16, 32'sd16}) begin
            fails++;
            $display("FAIL miss_seq: got store=%0d wait=%0d load=%0d sbeats=%0d lbeats=%0d exp 17 1 17 16 16",
                     n_st, n_wt, n_ld, st_beats, ld_beats);
        end
        tests++;
        if ({cpl0, cpl1} !== 2'b10) begin
            fails++;
            $display("FAIL miss_complete: got at load start %b then %b, exp 1 then 0", cpl0, cpl1);
        end
        use_ctrl = 1'b0;
    endtask

    initial begin
        test_reset;
        test_fill_zero_wait;
        test_writeback_latency;
        test_store_blocked;
        test_priority;
        test_fill_random;
        test_full_miss;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
Memory-side burst engine for the cache controller. It executes the 16-word line write-back (store) and line fill (load) requested by the cache control FSM, one word per handshake with main memory. It produces the word counter, the write-back-done flag and the FSM advance enable that the control FSM consumes. It sits between the cache control FSM / data array and the main-memory port.

Parameters:
DATA_W, 32, word width of the cache data array and memory bus.
ADDR_W, 32, byte address width of the memory bus; line address is ADDR_W-6 bits (16 words x 4 bytes).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
store  in  1  level from control FSM: write back current line
load  in  1  level from control FSM: fill current line
line_addr  in  ADDR_W-6  line-aligned address of the victim (store) or missed (load) line, stable while store/load high
cache_rdata  in  DATA_W  data-array read word at index cnt (write-back source)
cnt  out  4  current word index, drives data-array index and control FSM
complete  out  1  write-back finished, line may be fetched
fsm_en  out  1  advance enable for the control FSM state register
cache_we  out  1  data-array word write strobe (fill)
cache_wdata  out  DATA_W  fill word
mem_req  out  1  memory transfer request
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  {line_addr, cnt, 2'b00}
mem_wdata  out  DATA_W  equals cache_rdata during store beats
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  transfer accepted/finished this cycle; may be same cycle as mem_req

Behaviour:
- States: IDLE, ST_BEAT, LD_BEAT. Beat = one cycle with mem_req & mem_ack.
- Reset (rst=1 at edge): state IDLE, cnt=0, complete=0. Combinational outputs then: mem_req=0, cache_we=0, fsm_en=1. Reset mid-burst aborts immediately; no further memory requests.
- IDLE: mem_req=0, fsm_en=1. If store=1 and complete=0 -> ST_BEAT. Else if load=1 -> LD_BEAT, complete cleared to 0 at this edge. store has priority if both high.
- ST_BEAT: mem_req=1, mem_we=1, mem_wdata=cache_rdata, mem_addr from cnt. fsm_en = mem_ack. On ack: cnt+1; if cnt==15, cnt wraps to 0, complete set to 1, -> IDLE; else stay and issue next word the following cycle (back-to-back, no idle cycle).
- LD_BEAT: mem_req=1, mem_we=0. fsm_en = mem_ack. On ack: cache_we=1, cache_wdata=mem_rdata, written at index cnt (same cycle); cnt+1; if cnt==15, wrap to 0, -> IDLE.
- cache_we=0 outside LD_BEAT ack cycles; mem_addr/mem_wdata don't-care when mem_req=0.
- fsm_en low while a beat waits for ack, so the control FSM samples cnt==15 only on the final acked beat. Sequence: STORE leaves on final store ack -> WAIT sees complete=1 next edge -> LOAD -> engine starts fill -> final load ack returns FSM to RD_WR.
- complete holds 1 from the final store ack until the edge a load starts. With no load it stays 1; a new store is blocked until a load clears it.
- Memory stall: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
- Throughput: 1 word/cycle with zero-wait memory. Store or load = 16 beats minimum. IDLE-to-first-request = 1 cycle.

Test Plan:
- Reset: rst=1 for 2 cycles during a load at cnt=7 -> cnt=0, complete=0, mem_req=0, fsm_en=1 next cycle.
- Fill, zero-wait: load=1, line_addr=0x123, mem_ack tied 1, mem_rdata=0xA0+i -> 16 cache_we pulses, words i=0..15 get 0xA0+i at addresses 0x48C0+4i, cnt back to 0, fsm_en=1 each beat.
- Write-back, 3-cycle memory latency: store=1 -> each address/data held 3 cycles, fsm_en pulses only on ack, complete=1 after the 16th ack; addresses/data match cache_rdata per index.
- Full miss with dirty victim, engine driving the real control FSM: STORE 16 beats -> WAIT 1 cycle -> LOAD 16 beats -> RD_WR; complete cleared at the load start edge.
- Random ack gaps (0-5 cycles) on fill: exactly 16 writes, no duplicated or skipped index, cnt never exceeds 15.
- store and load both high in IDLE with complete=0 -> ST_BEAT selected, mem_we=1.
